// File: rtl/bbg_burst_if.sv
// rtl/bbg_burst_if.sv - control/status bundle between a burst requester and bbg_burst_ctrl
//
// Signals (direction as seen by the slave, i.e. the burst controller):
//   start, abort, continuous, sym_tick     in   burst request / termination / repeat / symbol strobe
//   burst_len [CNT_W], guard_len [CNT_W]   in   payload and guard lengths in symbols
//   flush_len [8]                          in   FIR tail flush length in symbols
//   gen_en, zero_din                       out  data generator enable, FIR input zeroing
//   amp [16]                               out  envelope gain for the mixer
//   busy, done, aborted                    out  status and one-clock event pulses
//   state [3]                              out  current sequencer state
interface bbg_burst_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             continuous;
    logic             sym_tick;
    logic [CNT_W-1:0] burst_len;
    logic [7:0]       flush_len;
    logic [CNT_W-1:0] guard_len;
    logic             gen_en;
    logic             zero_din;
    logic [15:0]      amp;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [2:0]       state;

    modport master (
        output start, abort, continuous, sym_tick, burst_len, flush_len, guard_len,
        input  gen_en, zero_din, amp, busy, done, aborted, state
    );

    modport slave (
        input  start, abort, continuous, sym_tick, burst_len, flush_len, guard_len,
        output gen_en, zero_din, amp, busy, done, aborted, state
    );
endinterface

// File: rtl/bbg_burst_ctrl.sv
// rtl/bbg_burst_ctrl.sv - TX burst sequencer: ramp-up, payload, FIR flush, ramp-down, guard
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous reset, active high
//   bus   bbg_burst_if.slave: start/abort/continuous/sym_tick and latched lengths in,
//         gen_en/zero_din/amp/busy/done/aborted/state out (all outputs registered)
module bbg_burst_ctrl #(
    parameter int CNT_W     = 16,
    parameter int RAMP_STEP = 1024,
    parameter int AMP_MAX   = 32767
) (
    input  logic        clk,
    input  logic        rst,
    bbg_burst_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_PAYLOAD   = 3'd2,
        S_FLUSH     = 3'd3,
        S_RAMP_DOWN = 3'd4,
        S_GUARD     = 3'd5
    } state_t;

    localparam logic [16:0] STEP17 = 17'(RAMP_STEP);
    localparam logic [16:0] MAX17  = 17'(AMP_MAX);
    localparam logic [15:0] STEP16 = 16'(RAMP_STEP);
    localparam logic [15:0] MAX16  = 16'(AMP_MAX);

    state_t           st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_inc, cnt_nxt;
    logic [CNT_W-1:0] blen_q, glen_q;
    logic [7:0]       flen_q;
    logic [15:0]      amp_q, amp_nxt;
    logic [16:0]      amp_sum;
    logic             ab_q, ab_nxt;          // burst is winding down because of an abort
    logic             take_start;
    logic             done_q, done_nxt, aborted_q, aborted_nxt;
    logic             gen_en_q, gen_en_nxt, zero_q, zero_nxt, busy_q, busy_nxt;
    logic             hit_burst, hit_flush, hit_guard;

    // A tick completes a phase when it is the len-th tick since state entry.
    assign cnt_inc   = cnt + CNT_W'(1);
    assign hit_burst = bus.sym_tick && (cnt_inc == blen_q);
    assign hit_flush = bus.sym_tick && (cnt_inc == CNT_W'(flen_q));
    assign hit_guard = bus.sym_tick && (cnt_inc == glen_q);
    assign amp_sum   = {1'b0, amp_q} + STEP17;

    // State register (also holds latched lengths, counter and registered outputs)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_IDLE;
            cnt       <= '0;
            blen_q    <= '0;
            flen_q    <= '0;
            glen_q    <= '0;
            ab_q      <= 1'b0;
            amp_q     <= '0;
            gen_en_q  <= 1'b0;
            zero_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            st        <= st_nxt;
            cnt       <= cnt_nxt;
            ab_q      <= ab_nxt;
            amp_q     <= amp_nxt;
            gen_en_q  <= gen_en_nxt;
            zero_q    <= zero_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            aborted_q <= aborted_nxt;
            if (take_start) begin
                blen_q <= bus.burst_len;
                flen_q <= bus.flush_len;
                glen_q <= bus.guard_len;
            end
        end
    end

    // Next-state logic
    always_comb begin
        st_nxt      = st;
        ab_nxt      = ab_q;
        take_start  = 1'b0;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        case (st)
            S_IDLE: begin
                // abort outranks start even here, so a simultaneous pair does nothing
                if (bus.start && !bus.abort && (bus.burst_len != '0)) begin
                    st_nxt     = S_RAMP_UP;
                    take_start = 1'b1;
                end
            end
            S_RAMP_UP, S_PAYLOAD, S_FLUSH: begin
                if (bus.abort) begin
                    st_nxt      = S_RAMP_DOWN;
                    aborted_nxt = 1'b1;
                    ab_nxt      = 1'b1;
                end else if (st == S_RAMP_UP) begin
                    if (amp_q == MAX16) st_nxt = S_PAYLOAD;
                end else if (st == S_PAYLOAD) begin
                    if (hit_burst) st_nxt = S_FLUSH;
                end else begin
                    if ((flen_q == 8'd0) || hit_flush) st_nxt = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                // ramp keeps going; only flag the abort so GUARD ends in IDLE without done
                if (bus.abort && !ab_q) begin
                    aborted_nxt = 1'b1;
                    ab_nxt      = 1'b1;
                end
                if (amp_q == '0) st_nxt = S_GUARD;
            end
            S_GUARD: begin
                if (bus.abort) begin
                    st_nxt      = S_IDLE;
                    aborted_nxt = !ab_q;
                    ab_nxt      = 1'b0;
                end else if ((glen_q == '0) || hit_guard) begin
                    if (ab_q) begin
                        st_nxt = S_IDLE;
                        ab_nxt = 1'b0;
                    end else begin
                        done_nxt = 1'b1;
                        st_nxt   = bus.continuous ? S_RAMP_UP : S_IDLE;
                    end
                end
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and the symbol counter
    always_comb begin
        amp_nxt = amp_q;
        case (st)
            S_RAMP_UP:   if (st_nxt == S_RAMP_UP) amp_nxt = (amp_sum > MAX17) ? MAX16 : amp_sum[15:0];
            S_RAMP_DOWN: amp_nxt = (amp_q >= STEP16) ? (amp_q - STEP16) : 16'd0;
            S_IDLE, S_GUARD: amp_nxt = '0;
            default:     amp_nxt = amp_q;
        endcase
        cnt_nxt    = (st_nxt != st) ? '0 : (bus.sym_tick ? cnt_inc : cnt);
        gen_en_nxt = (st_nxt == S_PAYLOAD);
        zero_nxt   = (st_nxt != S_PAYLOAD);
        busy_nxt   = (st_nxt != S_IDLE);
    end

    assign bus.state    = st;
    assign bus.amp      = amp_q;
    assign bus.gen_en   = gen_en_q;
    assign bus.zero_din = zero_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.aborted  = aborted_q;

endmodule
